// File: rtl/layer_priority_mux.sv
// N-layer priority compositor with per-frame player collision reporting.
// Optional macro LAYER_MUX_HIT_THRESH_EN enables per-layer hit-count thresholding.
module layer_priority_mux #(
  parameter int unsigned        NUM_LAYERS    = 8,
  parameter int unsigned        COLOR_W       = 8,
  parameter logic [COLOR_W-1:0] MASK_VALUE    = 8'h62,
  parameter logic [COLOR_W-1:0] DEFAULT_COLOR = 8'h76,
  parameter int unsigned        PLAYER_LAYER  = 2,
  parameter int unsigned        HIT_THRESH    = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              startOfFrame,
  input  logic [NUM_LAYERS*COLOR_W-1:0]     layer_colors,
  input  logic [NUM_LAYERS-1:0]             layer_en,
  output logic [COLOR_W-1:0]                RGB,
  output logic [$clog2(NUM_LAYERS+1)-1:0]   top_layer,
  output logic [NUM_LAYERS-1:0]             collisions,
  output logic                              collisions_valid
);

  localparam int unsigned TL_W = $clog2(NUM_LAYERS + 1);

  generate
    if (NUM_LAYERS < 2 || PLAYER_LAYER >= NUM_LAYERS || HIT_THRESH < 1) begin : g_bad_params
      $error("layer_priority_mux: illegal NUM_LAYERS/PLAYER_LAYER/HIT_THRESH combination");
    end
  endgenerate

  logic [NUM_LAYERS-1:0] opaque;
  logic [NUM_LAYERS-1:0] hit;
  logic [NUM_LAYERS-1:0] frame_hits;
  logic [COLOR_W-1:0]    win_color;
  logic [TL_W-1:0]       win_idx;

  always_comb begin
    opaque = '0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      opaque[i] = layer_en[i] && (layer_colors[i*COLOR_W +: COLOR_W] != MASK_VALUE);
    end
  end

  // Scan from lowest priority upward so the lowest-index opaque layer is written last.
  always_comb begin
    win_color = DEFAULT_COLOR;
    win_idx   = TL_W'(NUM_LAYERS);
    for (int unsigned i = NUM_LAYERS; i > 0; i--) begin
      if (opaque[i-1]) begin
        win_color = layer_colors[(i-1)*COLOR_W +: COLOR_W];
        win_idx   = TL_W'(i - 1);
      end
    end
  end

  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (i != PLAYER_LAYER) begin
        hit[i] = opaque[PLAYER_LAYER] && opaque[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      RGB       <= '0;
      top_layer <= '0;
    end else begin
      RGB       <= win_color;
      top_layer <= win_idx;
    end
  end

`ifdef LAYER_MUX_HIT_THRESH_EN
  localparam int unsigned        CNT_W   = $clog2(HIT_THRESH + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(HIT_THRESH);

  logic [NUM_LAYERS-1:0][CNT_W-1:0] cnt;

  // The startOfFrame pixel seeds the new frame's count rather than the old one.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
        if (startOfFrame) begin
          cnt[i] <= CNT_W'(hit[i]);
        end else if (hit[i] && (cnt[i] != CNT_MAX)) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    frame_hits = '0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      frame_hits[i] = (cnt[i] == CNT_MAX);
    end
  end
`else
  logic [NUM_LAYERS-1:0] acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (startOfFrame) begin
      acc <= hit;
    end else begin
      acc <= acc | hit;
    end
  end

  assign frame_hits = acc;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      collisions       <= '0;
      collisions_valid <= 1'b0;
    end else begin
      collisions_valid <= startOfFrame;
      if (startOfFrame) begin
        collisions <= frame_hits;
      end
    end
  end

endmodule

// File: tb/tb_layer_priority_mux.sv
// Directed bench for layer_priority_mux with a one-cycle-latency expectation scoreboard.
module tb_layer_priority_mux;

  localparam int NL = 8;
  localparam int CW = 8;
  localparam int TH = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            sof;
  logic [NL*CW-1:0] colors;
  logic [NL-1:0]   en;
  logic [CW-1:0]   rgb;
  logic [3:0]      top;
  logic [NL-1:0]   col;
  logic            colv;

  always #5 clk = ~clk;

  layer_priority_mux #(
    .NUM_LAYERS   (NL),
    .COLOR_W      (CW),
    .MASK_VALUE   (8'h62),
    .DEFAULT_COLOR(8'h76),
    .PLAYER_LAYER (2),
    .HIT_THRESH   (TH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .startOfFrame    (sof),
    .layer_colors    (colors),
    .layer_en        (en),
    .RGB             (rgb),
    .top_layer       (top),
    .collisions      (col),
    .collisions_valid(colv)
  );

  typedef struct {
    logic [7:0] rgb;
    logic [3:0] top;
    logic [7:0] col;
    logic       v;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] held_col = 8'h00;

  function automatic void ref_pix(input logic [NL*CW-1:0] c, input logic [NL-1:0] m,
                                  output logic [7:0] px, output logic [3:0] t);
    px = 8'h76;
    t  = 4'd8;
    for (int i = 0; i < NL; i++) begin
      if (m[i] && c[i*CW +: CW] != 8'h62) begin
        px = c[i*CW +: CW];
        t  = 4'(i);
        break;
      end
    end
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic clear_layers();
    for (int i = 0; i < NL; i++) colors[i*CW +: CW] = 8'h62;
    en = '1;
  endtask

  task automatic set_layer(input int idx, input logic [7:0] c);
    colors[idx*CW +: CW] = c;
  endtask

  // pub is the collision vector expected to be published when s is set.
  task automatic step(input string tag, input logic s, input logic r, input logic [7:0] pub);
    exp_t e;
    if (r) begin
      e = '{8'h00, 4'd0, 8'h00, 1'b0};
      held_col = 8'h00;
    end else begin
      ref_pix(colors, en, e.rgb, e.top);
      if (s) held_col = pub;
      e.col = held_col;
      e.v   = s;
    end
    sb.push_back(e);
    reset = r;
    sof   = s;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, ".rgb"}, rgb, e.rgb);
    check({tag, ".top"}, {4'b0, top}, {4'b0, e.top});
    check({tag, ".col"}, col, e.col);
    check({tag, ".valid"}, {7'b0, colv}, {7'b0, e.v});
  endtask

  initial begin
    reset = 1'b1;
    sof   = 1'b0;
    clear_layers();
    step("rst", 1'b0, 1'b1, 8'h00);
    step("rst_sof", 1'b1, 1'b1, 8'h00);
    step("idle", 1'b0, 1'b0, 8'h00);

    set_layer(3, 8'h1C);
    set_layer(5, 8'hE0);
    step("prio3", 1'b0, 1'b0, 8'h00);
    check("prio3.const", rgb, 8'h1C);
    en[3] = 1'b0;
    step("prio5", 1'b0, 1'b0, 8'h00);
    check("prio5.const", {4'b0, top}, 8'd5);

    clear_layers();
    step("dflt", 1'b0, 1'b0, 8'h00);
    check("dflt.const", rgb, 8'h76);
    step("mid_rst", 1'b0, 1'b1, 8'h00);
    step("post_rst", 1'b0, 1'b0, 8'h00);

`ifndef LAYER_MUX_HIT_THRESH_EN
    set_layer(2, 8'h11);
    set_layer(6, 8'h22);
    repeat (3) step("ovl26", 1'b0, 1'b0, 8'h00);
    clear_layers();
    step("gap", 1'b0, 1'b0, 8'h00);
    step("sof_pub", 1'b1, 1'b0, 8'h40);
    step("hold1", 1'b0, 1'b0, 8'h00);
    step("hold2", 1'b0, 1'b0, 8'h00);
    step("sof_zero", 1'b1, 1'b0, 8'h00);

    set_layer(2, 8'h11);
    set_layer(4, 8'h33);
    step("sof_edge", 1'b1, 1'b0, 8'h00);
    clear_layers();
    step("gap", 1'b0, 1'b0, 8'h00);
    step("sof_next", 1'b1, 1'b0, 8'h10);

    set_layer(2, 8'h11);
    set_layer(6, 8'h22);
    step("b2b_a", 1'b1, 1'b0, 8'h00);
    clear_layers();
    step("b2b_b", 1'b1, 1'b0, 8'h40);
    step("b2b_c", 1'b1, 1'b0, 8'h00);

    set_layer(2, 8'h11);
    set_layer(4, 8'h33);
    en[2] = 1'b0;
    repeat (2) step("pl_dis", 1'b0, 1'b0, 8'h00);
    clear_layers();
    step("sof_pl", 1'b1, 1'b0, 8'h00);

    set_layer(0, 8'h05);
    set_layer(2, 8'h11);
    set_layer(7, 8'h77);
    step("multi", 1'b0, 1'b0, 8'h00);
    clear_layers();
    step("sof_multi", 1'b1, 1'b0, 8'h81);

    set_layer(2, 8'h11);
    set_layer(4, 8'h33);
    step("pre_rst_ovl", 1'b0, 1'b0, 8'h00);
    clear_layers();
    step("discard_rst", 1'b0, 1'b1, 8'h00);
    step("sof_after_rst", 1'b1, 1'b0, 8'h00);
`else
    set_layer(2, 8'h11);
    set_layer(4, 8'h33);
    repeat (3) step("th3", 1'b0, 1'b0, 8'h00);
    clear_layers();
    step("sof_th3", 1'b1, 1'b0, 8'h00);

    set_layer(2, 8'h11);
    set_layer(4, 8'h33);
    repeat (4) step("th4", 1'b0, 1'b0, 8'h00);
    clear_layers();
    step("sof_th4", 1'b1, 1'b0, 8'h10);

    set_layer(2, 8'h11);
    set_layer(4, 8'h33);
    repeat (20) step("th20", 1'b0, 1'b0, 8'h00);
    clear_layers();
    step("sof_th20", 1'b1, 1'b0, 8'h10);
    step("sof_th_idle", 1'b1, 1'b0, 8'h00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
